// File: rtl/sparc_exu_ecl_eccfix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_ecl_eccfix_pkg
// Brief    : Shared field widths, entry metadata layout and FSM encoding
//            for the ECC fix scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sparc_exu_ecl_eccfix_pkg;

   localparam int RD_W   = 5;
   localparam int CWP_W  = 3;
   localparam int GL_W   = 2;
   localparam int TID_W  = 2;
   localparam int NTHR   = 4;
   localparam int META_W = RD_W + CWP_W + GL_W + TID_W;

   typedef struct packed {
      logic [TID_W-1:0] tid;
      logic [GL_W-1:0]  gl;
      logic [CWP_W-1:0] cwp;
      logic [RD_W-1:0]  rd;
   } fix_meta_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } fix_state_t;

endpackage
`default_nettype wire

// File: rtl/sparc_exu_ecl_eccfix_if.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_ecl_eccfix_if
// Brief    : M-stage capture, W-stage IRF fix write and ECL/IFU status bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sparc_exu_ecl_eccfix_if
   import sparc_exu_ecl_eccfix_pkg::*;
#(
   parameter int DW = 64
);
   logic              ecc_fix_vld_m;
   logic              ecc_ue_m;
   logic [RD_W-1:0]   eccctl_wb_rd_m;
   logic [CWP_W-1:0]  ecc_cwp_m;
   logic [GL_W-1:0]   ecc_gl_m;
   logic [TID_W-1:0]  ecc_tid_m;
   logic [DW-1:0]     ecc_corr_data_m;
   logic              wb_port_busy_w;

   logic              fix_wen_w;
   logic [RD_W-1:0]   fix_rd_w;
   logic [CWP_W-1:0]  fix_cwp_w;
   logic [GL_W-1:0]   fix_gl_w;
   logic [TID_W-1:0]  fix_tid_w;
   logic [DW-1:0]     fix_data_w;
   logic              ecl_fix_bubble_req;
   logic [NTHR-1:0]   exu_ifu_fix_pend;
   logic              ecl_fix_full;
   logic              fix_ovf_err;

   modport master (
      output ecc_fix_vld_m, ecc_ue_m, eccctl_wb_rd_m, ecc_cwp_m, ecc_gl_m,
             ecc_tid_m, ecc_corr_data_m, wb_port_busy_w,
      input  fix_wen_w, fix_rd_w, fix_cwp_w, fix_gl_w, fix_tid_w, fix_data_w,
             ecl_fix_bubble_req, exu_ifu_fix_pend, ecl_fix_full, fix_ovf_err
   );

   modport slave (
      input  ecc_fix_vld_m, ecc_ue_m, eccctl_wb_rd_m, ecc_cwp_m, ecc_gl_m,
             ecc_tid_m, ecc_corr_data_m, wb_port_busy_w,
      output fix_wen_w, fix_rd_w, fix_cwp_w, fix_gl_w, fix_tid_w, fix_data_w,
             ecl_fix_bubble_req, exu_ifu_fix_pend, ecl_fix_full, fix_ovf_err
   );

endinterface
`default_nettype wire

// File: rtl/sparc_exu_ecl_eccfix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_ecl_eccfix_fifo
// Brief    : DEPTH x W register FIFO with async reset and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module sparc_exu_ecl_eccfix_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 76
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   // Pointers are exactly log2(DEPTH) wide so they wrap without compare logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sparc_exu_ecl_eccfix.sv
`default_nettype none
// ============================================================================
// Module   : sparc_exu_ecl_eccfix
// Brief    : Queues correctable IRF errors and writes the fixes back on free
//            W slots, forcing a bubble when a fix has waited too long.
// Revision : 1.0 - initial release
// ============================================================================
module sparc_exu_ecl_eccfix
   import sparc_exu_ecl_eccfix_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int DW      = 64,
   parameter int MAXWAIT = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   sparc_exu_ecl_eccfix_if.slave  bus
);
   localparam int         CW        = $clog2(DEPTH) + 1;
   localparam int         EW        = DW + META_W;
   localparam logic [2:0] MAXWAIT_C = 3'(MAXWAIT);

   fix_meta_t       w_in_meta;
   fix_meta_t       w_head_meta;
   logic [EW-1:0]   w_din;
   logic [EW-1:0]   w_dout;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic [CW-1:0]   w_count_nxt;
   logic            w_enq;
   logic            w_deq;
   logic            w_head_vld;
   logic [2:0]      r_wait_cnt;
   logic [2:0]      w_wait_nxt;
   fix_state_t      r_state;
   fix_state_t      w_state_nxt;
   logic            r_ovf;
   logic [CW-1:0]   r_tid_cnt [NTHR];
   logic [NTHR-1:0] w_pend;

   assign w_in_meta = '{tid: bus.ecc_tid_m, gl: bus.ecc_gl_m,
                        cwp: bus.ecc_cwp_m, rd: bus.eccctl_wb_rd_m};
   assign w_din       = {w_in_meta, bus.ecc_corr_data_m};
   assign w_enq       = bus.ecc_fix_vld_m & ~bus.ecc_ue_m & ~w_full;
   assign w_head_vld  = ~w_empty;
   assign w_deq       = w_head_vld & ~bus.wb_port_busy_w;
   assign w_head_meta = fix_meta_t'(w_dout[EW-1:DW]);
   assign w_count_nxt = w_count + CW'(w_enq) - CW'(w_deq);

   sparc_exu_ecl_eccfix_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_enq),
      .pop   (w_deq),
      .din   (w_din),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // Fields are gated by head_vld so stale RAM contents never reach the IRF.
   assign bus.fix_wen_w  = w_deq;
   assign bus.fix_rd_w   = w_head_vld ? w_head_meta.rd  : '0;
   assign bus.fix_cwp_w  = w_head_vld ? w_head_meta.cwp : '0;
   assign bus.fix_gl_w   = w_head_vld ? w_head_meta.gl  : '0;
   assign bus.fix_tid_w  = w_head_vld ? w_head_meta.tid : '0;
   assign bus.fix_data_w = w_head_vld ? w_dout[DW-1:0] : '0;

   always_comb begin
      w_wait_nxt = r_wait_cnt;
      if (!w_head_vld || w_deq)
         w_wait_nxt = 3'd0;
      else if (r_wait_cnt != 3'd7)
         w_wait_nxt = r_wait_cnt + 3'd1;

      w_state_nxt = ST_WAIT;
      if (w_count_nxt == '0)
         w_state_nxt = ST_IDLE;
      else if (w_wait_nxt >= MAXWAIT_C)
         w_state_nxt = ST_FORCE;
   end

   always_comb begin
      w_pend = '0;
      for (int t = 0; t < NTHR; t++) w_pend[t] = (r_tid_cnt[t] != '0);
   end

   // Per-thread occupancy lets a thread's pend survive until its last entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
         r_state    <= ST_IDLE;
         r_ovf      <= 1'b0;
         for (int t = 0; t < NTHR; t++) r_tid_cnt[t] <= '0;
      end else begin
         r_wait_cnt <= w_wait_nxt;
         r_state    <= w_state_nxt;
         if (bus.ecc_fix_vld_m && !bus.ecc_ue_m && w_full) r_ovf <= 1'b1;
         for (int t = 0; t < NTHR; t++)
            r_tid_cnt[t] <= r_tid_cnt[t]
                          + CW'(w_enq && (w_in_meta.tid == TID_W'(t)))
                          - CW'(w_deq && (w_head_meta.tid == TID_W'(t)));
      end
   end

   assign bus.ecl_fix_bubble_req = (r_state == ST_FORCE);
   assign bus.exu_ifu_fix_pend   = w_pend;
   assign bus.ecl_fix_full       = w_full;
   assign bus.fix_ovf_err        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_ecl_eccfix.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparc_exu_ecl_eccfix
// Brief    : Directed self-checking bench for the ECC fix scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparc_exu_ecl_eccfix;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   sparc_exu_ecl_eccfix_if #(.DW(64)) bus ();

   sparc_exu_ecl_eccfix #(
      .DEPTH   (2),
      .DW      (64),
      .MAXWAIT (7)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cap(input logic [1:0] tid, input logic [4:0] rd, input logic [63:0] data);
      bus.ecc_fix_vld_m   = 1'b1;
      bus.ecc_tid_m       = tid;
      bus.eccctl_wb_rd_m  = rd;
      bus.ecc_corr_data_m = data;
      tick();
      bus.ecc_fix_vld_m   = 1'b0;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.ecc_fix_vld_m   = 1'b0;
      bus.ecc_ue_m        = 1'b0;
      bus.eccctl_wb_rd_m  = '0;
      bus.ecc_cwp_m       = '0;
      bus.ecc_gl_m        = '0;
      bus.ecc_tid_m       = '0;
      bus.ecc_corr_data_m = '0;
      bus.wb_port_busy_w  = 1'b0;
      tick();
      tick();
      chk("rst_wen",  bus.fix_wen_w, 0);
      chk("rst_pend", bus.exu_ifu_fix_pend, 0);
      chk("rst_data", bus.fix_data_w, 0);
      reset = 1'b0;
      tick();
      chk("idle_full", bus.ecl_fix_full, 0);
      chk("idle_ovf",  bus.fix_ovf_err, 0);
      chk("idle_req",  bus.ecl_fix_bubble_req, 0);

      // Single CE with a free port: write in the very next cycle.
      bus.ecc_cwp_m = 3'h5;
      bus.ecc_gl_m  = 2'h1;
      bus.ecc_fix_vld_m   = 1'b1;
      bus.ecc_tid_m       = 2'd2;
      bus.eccctl_wb_rd_m  = 5'h11;
      bus.ecc_corr_data_m = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("ce_pre_wen", bus.fix_wen_w, 0);
      tick();
      bus.ecc_fix_vld_m = 1'b0;
      #1;
      chk("ce_wen",  bus.fix_wen_w, 1);
      chk("ce_rd",   bus.fix_rd_w, 5'h11);
      chk("ce_tid",  bus.fix_tid_w, 2'd2);
      chk("ce_cwp",  bus.fix_cwp_w, 3'h5);
      chk("ce_gl",   bus.fix_gl_w, 2'h1);
      chk("ce_data", bus.fix_data_w, 64'hDEAD_BEEF_0000_0001);
      chk("ce_pend", bus.exu_ifu_fix_pend, 4'b0100);
      tick();
      chk("ce_wen_after",  bus.fix_wen_w, 0);
      chk("ce_pend_after", bus.exu_ifu_fix_pend, 4'b0000);

      // UE suppresses capture.
      bus.ecc_ue_m = 1'b1;
      cap(2'd1, 5'h02, 64'h1234);
      bus.ecc_ue_m = 1'b0;
      chk("ue_wen",  bus.fix_wen_w, 0);
      chk("ue_pend", bus.exu_ifu_fix_pend, 4'b0000);
      tick();
      chk("ue_wen2", bus.fix_wen_w, 0);

      // Starvation: bubble_req on the 8th busy cycle with a valid head.
      bus.wb_port_busy_w = 1'b1;
      cap(2'd0, 5'h03, 64'hCAFE_0000_0000_0003);
      for (int k = 1; k <= 7; k++) begin
         chk("starve_req_lo", bus.ecl_fix_bubble_req, 0);
         chk("starve_wen_lo", bus.fix_wen_w, 0);
         tick();
      end
      chk("starve_req_hi", bus.ecl_fix_bubble_req, 1);
      chk("starve_pend",   bus.exu_ifu_fix_pend, 4'b0001);
      tick();
      tick();
      chk("starve_req_hold", bus.ecl_fix_bubble_req, 1);
      tick();
      bus.wb_port_busy_w = 1'b0;
      #1;
      chk("starve_wen", bus.fix_wen_w, 1);
      chk("starve_rd",  bus.fix_rd_w, 5'h03);
      tick();
      chk("starve_req_clr", bus.ecl_fix_bubble_req, 0);
      chk("starve_wen_clr", bus.fix_wen_w, 0);

      // Fill and overflow.
      bus.wb_port_busy_w = 1'b1;
      cap(2'd0, 5'h01, 64'hAAAA);
      chk("fill_full1", bus.ecl_fix_full, 0);
      cap(2'd1, 5'h02, 64'hBBBB);
      chk("fill_full2", bus.ecl_fix_full, 1);
      chk("fill_ovf0",  bus.fix_ovf_err, 0);
      chk("fill_pend",  bus.exu_ifu_fix_pend, 4'b0011);
      cap(2'd0, 5'h07, 64'hCCCC);
      chk("ovf_set",  bus.fix_ovf_err, 1);
      chk("ovf_full", bus.ecl_fix_full, 1);
      bus.wb_port_busy_w = 1'b0;
      #1;
      chk("drain0_wen",  bus.fix_wen_w, 1);
      chk("drain0_tid",  bus.fix_tid_w, 2'd0);
      chk("drain0_rd",   bus.fix_rd_w, 5'h01);
      chk("drain0_data", bus.fix_data_w, 64'hAAAA);
      tick();
      chk("drain1_wen",  bus.fix_wen_w, 1);
      chk("drain1_tid",  bus.fix_tid_w, 2'd1);
      chk("drain1_rd",   bus.fix_rd_w, 5'h02);
      chk("drain1_pend", bus.exu_ifu_fix_pend, 4'b0010);
      chk("drain1_full", bus.ecl_fix_full, 0);
      tick();
      chk("drained_wen",  bus.fix_wen_w, 0);
      chk("drained_pend", bus.exu_ifu_fix_pend, 4'b0000);
      chk("ovf_sticky",   bus.fix_ovf_err, 1);

      // Same-tid ordering: pend holds until the last tid 3 entry leaves.
      bus.wb_port_busy_w = 1'b1;
      cap(2'd3, 5'h04, 64'h4444);
      cap(2'd3, 5'h05, 64'h5555);
      bus.wb_port_busy_w = 1'b0;
      #1;
      chk("tid3_first_rd", bus.fix_rd_w, 5'h04);
      tick();
      chk("tid3_pend_mid",  bus.exu_ifu_fix_pend, 4'b1000);
      chk("tid3_second_rd", bus.fix_rd_w, 5'h05);
      chk("tid3_second_wen", bus.fix_wen_w, 1);
      tick();
      chk("tid3_pend_clr", bus.exu_ifu_fix_pend, 4'b0000);

      // Async reset while two entries wait and a bubble is requested.
      bus.wb_port_busy_w = 1'b1;
      cap(2'd1, 5'h08, 64'h8888);
      cap(2'd2, 5'h09, 64'h9999);
      for (int k = 0; k < 20 && bus.ecl_fix_bubble_req !== 1'b1; k++) tick();
      chk("rstmid_req_pre",  bus.ecl_fix_bubble_req, 1);
      chk("rstmid_full_pre", bus.ecl_fix_full, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid_req",  bus.ecl_fix_bubble_req, 0);
      chk("rstmid_full", bus.ecl_fix_full, 0);
      chk("rstmid_pend", bus.exu_ifu_fix_pend, 0);
      chk("rstmid_ovf",  bus.fix_ovf_err, 0);
      chk("rstmid_rd",   bus.fix_rd_w, 0);
      chk("rstmid_wen",  bus.fix_wen_w, 0);
      tick();
      reset = 1'b0;
      bus.wb_port_busy_w = 1'b0;
      #1;
      chk("post_rst_wen", bus.fix_wen_w, 0);
      tick();
      chk("post_rst_wen2", bus.fix_wen_w, 0);
      chk("post_rst_full", bus.ecl_fix_full, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
